// File: rtl/instruction_fetch_unit.sv
// Program counter plus IF/ID pipeline register feeding a combinational instruction memory.
// Supports stall, flush and redirect, and halts with a sticky fault on a bad fetch address.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] word_index;
    logic [31:0] pc_next_seq;
    logic        bad;

    assign word_index  = {2'b00, pc[31:2]};
    assign imem_addr   = word_index;
    assign pc_next_seq = pc + 32'd4;
    assign bad         = (pc[1:0] != 2'b00) || (word_index >= IMEM_DEPTH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            if_id_instr    <= '0;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
            fetch_fault    <= 1'b0;
            fetch_count    <= '0;
        end else begin
            unique case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    // if_id_pc_plus4 is deliberately left alone on redirect/flush; valid qualifies it.
                    if (redirect) begin
                        pc          <= redirect_pc;
                        if_id_instr <= '0;
                        if_id_valid <= 1'b0;
                    end else if (flush) begin
                        if_id_instr <= '0;
                        if_id_valid <= 1'b0;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (bad) begin
                        if_id_valid <= 1'b0;
                        fetch_fault <= 1'b1;
                        state       <= HALT;
                    end else begin
                        if_id_instr    <= imem_instr;
                        if_id_pc_plus4 <= pc_next_seq;
                        if_id_valid    <= 1'b1;
                        pc             <= pc_next_seq;
                        fetch_count    <= fetch_count + 32'd1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized
// stall/flush/redirect/reset traffic compared against a behavioural model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned DEPTH  = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    // Behavioural model state; "halted" is simply a latched fault.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_fault, m_boot;

    instruction_fetch_unit #(
        .RESET_PC  (RST_PC),
        .IMEM_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .stall         (stall),
        .flush         (flush),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid),
        .fetch_fault   (fetch_fault),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < DEPTH) ? mem[imem_addr[4:0]] : 32'hDEAD_BEEF;

    function automatic logic [161:0] dut_vec();
        return {pc, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_fault, fetch_count, imem_addr};
    endfunction

    function automatic logic [161:0] model_vec();
        return {m_pc, m_instr, m_pc4, m_valid, m_fault, m_count, m_pc / 32'd4};
    endfunction

    task automatic model_step(input logic r, input logic s, input logic f, input logic d,
                              input logic [31:0] rpc);
        if (!r) begin
            m_pc = RST_PC; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
            m_fault = 1'b0; m_count = '0; m_boot = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_fault) begin
            m_boot = 1'b0;
        end else if (d) begin
            m_pc = rpc; m_instr = '0; m_valid = 1'b0;
        end else if (f) begin
            m_instr = '0; m_valid = 1'b0;
        end else if (s) begin
            m_boot = 1'b0;
        end else if ((m_pc % 4 != 0) || (m_pc / 4 >= DEPTH)) begin
            m_valid = 1'b0; m_fault = 1'b1;
        end else begin
            m_instr = mem[m_pc[6:2]];
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end
    endtask

    // Drive one cycle of inputs, clock it, then advance the model; outputs settle by #1.
    task automatic tick(input logic r, input logic s, input logic f, input logic d,
                        input logic [31:0] rpc);
        rst_n = r; stall = s; flush = f; redirect = d; redirect_pc = rpc;
        @(posedge clk);
        #1;
        model_step(r, s, f, d, rpc);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
        checks++;
        if (dut_vec() !== {RST_PC, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_values got %h exp %h", dut_vec(),
                     {RST_PC, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0});
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        checks++;
        if ({pc, if_id_valid, fetch_count} !== {RST_PC, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL boot_ignores_inputs got pc=%h v=%b cnt=%0d exp pc=%h v=0 cnt=0",
                     pc, if_id_valid, fetch_count, RST_PC);
        end
    endtask

    task automatic test_program();
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'h20010003; exp_instr[1] = 32'h20020003; exp_instr[2] = 32'h00221818;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
            checks++;
            if ({if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count} !==
                {exp_instr[i], 32'(4 * (i + 1)), 1'b1, 32'(i + 1)}) begin
                errors++;
                $display("FAIL program_fetch%0d got instr=%h p4=%h v=%b cnt=%0d exp instr=%h p4=%h v=1 cnt=%0d",
                         i, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count,
                         exp_instr[i], 4 * (i + 1), i + 1);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, '0);
            checks++;
            if ({pc, if_id_instr, if_id_valid, fetch_count} !== {32'd8, 32'h20020003, 1'b1, 32'd2}) begin
                errors++;
                $display("FAIL stall_hold%0d got pc=%h instr=%h v=%b cnt=%0d exp pc=8 instr=20020003 v=1 cnt=2",
                         i, pc, if_id_instr, if_id_valid, fetch_count);
            end
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({if_id_instr, if_id_pc_plus4, fetch_count} !== {32'h00221818, 32'd12, 32'd3}) begin
            errors++;
            $display("FAIL stall_release got instr=%h p4=%h cnt=%0d exp instr=00221818 p4=c cnt=3",
                     if_id_instr, if_id_pc_plus4, fetch_count);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 32'h10);
        checks++;
        if ({pc, if_id_valid, if_id_instr, fetch_count, if_id_pc_plus4} !==
            {32'h10, 1'b0, 32'd0, 32'd2, 32'd8}) begin
            errors++;
            $display("FAIL redirect_priority got pc=%h v=%b instr=%h cnt=%0d p4=%h exp pc=10 v=0 instr=0 cnt=2 p4=8",
                     pc, if_id_valid, if_id_instr, fetch_count, if_id_pc_plus4);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({if_id_instr, if_id_pc_plus4, if_id_valid} !== {32'h10220014, 32'h14, 1'b1}) begin
            errors++;
            $display("FAIL redirect_target got instr=%h p4=%h v=%b exp instr=10220014 p4=14 v=1",
                     if_id_instr, if_id_pc_plus4, if_id_valid);
        end
        // flush alone: bubble inserted, pc refetched
        tick(1'b1, 1'b0, 1'b1, 1'b0, '0);
        checks++;
        if ({pc, if_id_valid, if_id_instr, if_id_pc_plus4} !== {32'h14, 1'b0, 32'd0, 32'h14}) begin
            errors++;
            $display("FAIL flush_bubble got pc=%h v=%b instr=%h p4=%h exp pc=14 v=0 instr=0 p4=14",
                     pc, if_id_valid, if_id_instr, if_id_pc_plus4);
        end
    endtask

    task automatic test_range_fault();
        do_reset();
        for (int i = 0; i < 32; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({pc, fetch_count, fetch_fault, if_id_valid} !== {32'h80, 32'd32, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL range_last_good got pc=%h cnt=%0d f=%b v=%b exp pc=80 cnt=32 f=0 v=1",
                     pc, fetch_count, fetch_fault, if_id_valid);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({pc, fetch_count, fetch_fault, if_id_valid} !== {32'h80, 32'd32, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL range_fault got pc=%h cnt=%0d f=%b v=%b exp pc=80 cnt=32 f=1 v=0",
                     pc, fetch_count, fetch_fault, if_id_valid);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
            checks++;
            if ({pc, fetch_fault, if_id_valid, fetch_count} !== {32'h80, 1'b1, 1'b0, 32'd32}) begin
                errors++;
                $display("FAIL halt_ignores_redirect%0d got pc=%h f=%b v=%b cnt=%0d exp pc=80 f=1 v=0 cnt=32",
                         i, pc, fetch_fault, if_id_valid, fetch_count);
            end
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h6);
        checks++;
        if ({pc, fetch_fault} !== {32'h6, 1'b0}) begin
            errors++;
            $display("FAIL misalign_redirect got pc=%h f=%b exp pc=6 f=0", pc, fetch_fault);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({pc, fetch_fault, if_id_valid, fetch_count} !== {32'h6, 1'b1, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL misalign_fault got pc=%h f=%b v=%b cnt=%0d exp pc=6 f=1 v=0 cnt=1",
                     pc, fetch_fault, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (dut_vec() !== {RST_PC, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL midrun_reset got %h exp %h", dut_vec(),
                     {RST_PC, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0});
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({pc, if_id_valid} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL midrun_boot got pc=%h v=%b exp pc=0 v=0", pc, if_id_valid);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count} !== {32'h20010003, 32'd4, 1'b1, 32'd1}) begin
            errors++;
            $display("FAIL midrun_refetch got instr=%h p4=%h v=%b cnt=%0d exp instr=20010003 p4=4 v=1 cnt=1",
                     if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_random();
        logic        r, s, f, d;
        logic [31:0] rpc;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = !(($urandom_range(0, 59) == 0) || (m_fault && $urandom_range(0, 7) == 0));
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 6) == 0);
            d = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0:       rpc = $urandom;
                1:       rpc = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
                2:       rpc = {24'd0, 6'($urandom_range(32, 63)), 2'b00};
                default: rpc = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            endcase
            tick(r, s, f, d, rpc);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d got %h exp %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h20010003;
        mem[1] = 32'h20020003;
        mem[2] = 32'h00221818;
        mem[4] = 32'h10220014;
        test_reset();
        test_program();
        test_stall();
        test_redirect();
        test_range_fault();
        test_misaligned();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
